// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_t       : controller state encoding (IDLE / RUN / DONE)
//   - DIV_WIDTH_DEFAULT : default operand/result width
//   - cnt_width()       : width of the iteration counter, clog2(width+1),
//                         so the counter can hold the value WIDTH itself
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration (purely combinational):
// the partial remainder is shifted left by one, the next dividend bit enters
// at the LSB, the divisor is trial-subtracted, and the difference is kept only
// when it does not borrow. The quotient bit is the inverted borrow.
//
// Ports:
//   part_rem  in  WIDTH  partial remainder from the previous iteration
//   dvd_bit   in  1      next dividend bit (MSB first)
//   divisor   in  WIDTH  divisor magnitude
//   next_rem  out WIDTH  partial remainder after this iteration
//   q_bit     out 1      quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Shift, trial subtract and restore-or-keep selection.
    always_comb begin
        shifted_s = {part_rem, dvd_bit};
        // One extra MSB so the borrow of the trial subtraction is visible.
        trial_s   = {1'b0, shifted_s} - {2'b00, divisor};
        if (trial_s[WIDTH+1]) begin
            q_bit    = 1'b0;
            next_rem = shifted_s[WIDTH-1:0];
        end else begin
            q_bit    = 1'b1;
            next_rem = trial_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/nbit_seq_divider.sv
// -----------------------------------------------------------------------------
// nbit_seq_divider
// Sequential restoring divider, one quotient bit per clock, MSB first.
// A start is accepted while not busy (IDLE or DONE); WIDTH iterations later the
// results are registered and o_done pulses for one cycle. A zero divisor
// bypasses the iterations: one pass through RUN, then DONE with o_dbz=1,
// Quo=all ones and Rem=Q.
//
// Build option:
//   NBIT_DIV_SIGNED_EN  when defined, i_signed selects two's-complement mode
//                       (magnitude division, quotient truncated toward zero,
//                       remainder takes the sign of Q). When undefined every
//                       operation is unsigned and no negation logic exists.
//
// Ports:
//   i_clk     in  1      clock, rising edge
//   i_rst_n   in  1      synchronous active-low reset
//   i_start   in  1      begin a division (ignored while busy)
//   i_signed  in  1      two's-complement mode select, sampled with i_start
//   Q         in  WIDTH  dividend, sampled with i_start
//   M         in  WIDTH  divisor, sampled with i_start
//   o_busy    out 1      high while in RUN
//   o_done    out 1      one-cycle pulse when results are updated
//   Quo       out WIDTH  quotient, held until the next completion
//   Rem       out WIDTH  remainder, held until the next completion
//   o_dbz     out 1      divide-by-zero flag, held with the results
// -----------------------------------------------------------------------------
module nbit_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] M,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] Quo,
    output logic [WIDTH-1:0] Rem,
    output logic             o_dbz
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_r;
    logic [WIDTH-1:0] dvd_r;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic [WIDTH-1:0] part_rem_r; // running partial remainder
    logic [CW-1:0]    cnt_r;      // iterations still to perform
    logic             dbz_pend_r; // current RUN pass is a divide-by-zero bypass
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic [WIDTH-1:0] q_mag_s;
    logic [WIDTH-1:0] m_mag_s;
    logic             m_zero_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_qbit_s;
    logic [WIDTH-1:0] quo_raw_s;
    logic [WIDTH-1:0] quo_fin_s;
    logic [WIDTH-1:0] rem_fin_s;

    assign m_zero_s = (M == {WIDTH{1'b0}});

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .part_rem (part_rem_r),
        .dvd_bit  (dvd_r[WIDTH-1]),
        .divisor  (dvs_r),
        .next_rem (step_rem_s),
        .q_bit    (step_qbit_s)
    );

    // Quotient including the bit produced in the final iteration.
    assign quo_raw_s = {dvd_r[WIDTH-2:0], step_qbit_s};

`ifdef NBIT_DIV_SIGNED_EN
    logic q_neg_s;
    logic m_neg_s;
    logic neg_quo_r;
    logic neg_rem_r;

    // Operand signs and magnitudes; the most negative value maps to its own
    // bit pattern, which read as unsigned is the correct magnitude.
    always_comb begin
        q_neg_s = i_signed & Q[WIDTH-1];
        m_neg_s = i_signed & M[WIDTH-1];
        if (q_neg_s) begin
            q_mag_s = ~Q + WIDTH'(1);
        end else begin
            q_mag_s = Q;
        end
        if (m_neg_s) begin
            m_mag_s = ~M + WIDTH'(1);
        end else begin
            m_mag_s = M;
        end
    end

    // Sign correction of the final results (quotient wraps for MIN / -1).
    always_comb begin
        if (neg_quo_r) begin
            quo_fin_s = ~quo_raw_s + WIDTH'(1);
        end else begin
            quo_fin_s = quo_raw_s;
        end
        if (neg_rem_r) begin
            rem_fin_s = ~step_rem_s + WIDTH'(1);
        end else begin
            rem_fin_s = step_rem_s;
        end
    end

    // Result sign flags captured with the operands.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if ((state_r != RUN) && i_start) begin
            neg_quo_r <= q_neg_s ^ m_neg_s;
            neg_rem_r <= q_neg_s;
        end
    end
`else
    logic unused_signed_s;
    assign unused_signed_s = i_signed;

    // Unsigned-only build: operands and results pass straight through.
    always_comb begin
        q_mag_s   = Q;
        m_mag_s   = M;
        quo_fin_s = quo_raw_s;
        rem_fin_s = step_rem_s;
    end
`endif

    // Controller FSM, iteration datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            dvd_r      <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            part_rem_r <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            dbz_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            quo_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (i_start) begin
                        // A zero divisor keeps raw Q so it can be returned as Rem.
                        dvd_r      <= m_zero_s ? Q : q_mag_s;
                        dvs_r      <= m_mag_s;
                        part_rem_r <= {WIDTH{1'b0}};
                        cnt_r      <= CW'(WIDTH);
                        dbz_pend_r <= m_zero_s;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    if (dbz_pend_r) begin
                        dbz_pend_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        dbz_r      <= 1'b1;
                        quo_r      <= {WIDTH{1'b1}};
                        rem_r      <= dvd_r;
                        state_r    <= DONE;
                    end else begin
                        part_rem_r <= step_rem_s;
                        dvd_r      <= quo_raw_s;
                        cnt_r      <= cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b0;
                            quo_r   <= quo_fin_s;
                            rem_r   <= rem_fin_s;
                            state_r <= DONE;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_dbz  = dbz_r;
    assign Quo    = quo_r;
    assign Rem    = rem_r;

endmodule

// File: tb/tb_nbit_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_nbit_seq_divider
// Scoreboard bench for nbit_seq_divider: an 8-bit and a 16-bit instance share
// clock and reset. Expected results come from an arithmetic model evaluated
// when a start is driven; they are popped and compared on o_done. Latency is
// counted in rising edges with the accepting edge counted as the first.
// Honours NBIT_DIV_SIGNED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_nbit_seq_divider;

`ifdef NBIT_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel_b = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] q_v = 32'd0;
    logic [31:0] m_v = 32'd0;

    logic        start_a, start_b;
    logic        busy_a, done_a, dbz_a;
    logic [7:0]  quo_a, rem_a;
    logic        busy_b, done_b, dbz_b;
    logic [15:0] quo_b, rem_b;

    logic        busy_s, done_s, dbz_s;
    logic [31:0] quo_s, rem_s;

    exp_t sb_q[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel_b;
    assign start_b = start & sel_b;
    assign busy_s  = sel_b ? busy_b : busy_a;
    assign done_s  = sel_b ? done_b : done_a;
    assign dbz_s   = sel_b ? dbz_b  : dbz_a;
    assign quo_s   = sel_b ? {16'd0, quo_b} : {24'd0, quo_a};
    assign rem_s   = sel_b ? {16'd0, rem_b} : {24'd0, rem_a};

    nbit_seq_divider #(.WIDTH(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_signed(sgn),
        .Q(q_v[7:0]), .M(m_v[7:0]), .o_busy(busy_a), .o_done(done_a),
        .Quo(quo_a), .Rem(rem_a), .o_dbz(dbz_a)
    );

    nbit_seq_divider #(.WIDTH(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_signed(sgn),
        .Q(q_v[15:0]), .M(m_v[15:0]), .o_busy(busy_b), .o_done(done_b),
        .Quo(quo_b), .Rem(rem_b), .o_dbz(dbz_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic exp_t model(input int w, input bit s, input logic [31:0] q, input logic [31:0] m);
        exp_t   e;
        longint mask, qq, mm, sq, sm;
        mask = (longint'(1) << w) - longint'(1);
        qq   = longint'(q) & mask;
        mm   = longint'(m) & mask;
        if (mm == 0) begin
            e.quo = 32'(mask);
            e.rem = 32'(qq);
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            if (s && SIGNED_EN) begin
                sq = qq[w-1] ? qq - (longint'(1) << w) : qq;
                sm = mm[w-1] ? mm - (longint'(1) << w) : mm;
                e.quo = 32'((sq / sm) & mask);
                e.rem = 32'((sq % sm) & mask);
            end else begin
                e.quo = 32'(qq / mm);
                e.rem = 32'(qq % mm);
            end
            e.dbz = 1'b0;
            e.lat = w + 1;
        end
        return e;
    endfunction

    // Drive a request (caller picks the moment) and record its expectation.
    task automatic start_op(input bit b, input bit s, input logic [31:0] q, input logic [31:0] m);
        sel_b = b;
        sgn   = s;
        q_v   = q;
        m_v   = m;
        start = 1'b1;
        sb_q.push_back(model(b ? 16 : 8, s, q, m));
    endtask

    // Let the request be accepted, wait for o_done, compare with the scoreboard.
    task automatic finish_op(input string tag, input bit junk);
        int lat;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        if (sb_q.size() > 0 && sb_q[0].lat > 2) check_eq({tag, "/busy"}, {31'd0, busy_s}, 32'd1);
        while (!done_s && lat < 40) begin
            if (junk) begin
                start = (lat == 3) || (lat == 5);
                q_v   = 32'h0000_0055;
                m_v   = 32'h0000_0003;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!done_s) begin
            check_eq({tag, "/timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            last_e = sb_q.pop_front();
            check_eq({tag, "/quo"}, quo_s, last_e.quo);
            check_eq({tag, "/rem"}, rem_s, last_e.rem);
            check_eq({tag, "/dbz"}, {31'd0, dbz_s}, {31'd0, last_e.dbz});
            check_eq({tag, "/lat"}, 32'(lat), 32'(last_e.lat));
        end
    endtask

    // One more edge with no request: pulse gone, results held.
    task automatic check_hold(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, "/done_low"}, {31'd0, done_s}, 32'd0);
        check_eq({tag, "/quo_held"}, quo_s, last_e.quo);
        check_eq({tag, "/rem_held"}, rem_s, last_e.rem);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst/done", {31'd0, done_a}, 32'd0);
        check_eq("rst/dbz",  {31'd0, dbz_a},  32'd0);
        check_eq("rst/quo",  {24'd0, quo_a},  32'd0);
        check_eq("rst/rem",  {24'd0, rem_a},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 125/3
        @(negedge clk); start_op(1'b0, 1'b0, 32'd125, 32'd3);
        finish_op("u125_3", 1'b0);
        check_hold("u125_3");

        // Signed sign combinations
        @(negedge clk); start_op(1'b0, 1'b1, 32'h0000_00F9, 32'd3);
        finish_op("s_m7_3", 1'b0);
        @(negedge clk); start_op(1'b0, 1'b1, 32'd7, 32'h0000_00FD);
        finish_op("s_7_m3", 1'b0);
        @(negedge clk); start_op(1'b0, 1'b1, 32'h0000_00F9, 32'h0000_00FD);
        finish_op("s_m7_m3", 1'b0);

        // Divide by zero
        @(negedge clk); start_op(1'b0, 1'b0, 32'd7, 32'd0);
        finish_op("dbz_7_0", 1'b0);

        // MIN / -1 with start pulses during RUN
        @(negedge clk); start_op(1'b0, 1'b1, 32'h0000_0080, 32'h0000_00FF);
        finish_op("s_min_m1", 1'b1);
        check_hold("s_min_m1");
        check_eq("s_min_m1/idle_busy", {31'd0, busy_a}, 32'd0);

        // Reset four cycles into RUN, together with a start request
        @(negedge clk);
        sel_b = 1'b0; sgn = 1'b0; q_v = 32'd200; m_v = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_run/busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_run/done", {31'd0, done_a}, 32'd0);
        check_eq("rst_run/dbz",  {31'd0, dbz_a},  32'd0);
        check_eq("rst_run/quo",  {24'd0, quo_a},  32'd0);
        check_eq("rst_run/rem",  {24'd0, rem_a},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_a) n_done++;
        end
        check_eq("rst_run/no_done", 32'(n_done), 32'd0);

        @(negedge clk); start_op(1'b0, 1'b0, 32'd200, 32'd7);
        finish_op("u200_7", 1'b0);

        // 16-bit instance with a back-to-back start issued in DONE
        @(negedge clk); start_op(1'b1, 1'b0, 32'd60000, 32'd7);
        finish_op("w16_60000_7", 1'b0);
        start_op(1'b1, 1'b0, 32'd40000, 32'd123);
        finish_op("w16_b2b", 1'b0);
        start_op(1'b1, 1'b1, 32'h0000_8AD0, 32'd7);
        finish_op("w16_s_b2b", 1'b0);
        check_hold("w16_s_b2b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
